// File: rtl/clk_div_gen.sv
// clk_div_gen: symbol clock and run-time selectable PCLK derived from the bit-rate clock.
// Optional PCLK gating input Pclk_Gate_En is present when CLK_DIV_GATE_EN is defined.
//
// state  | meaning
// RUN    | PCLK stable at Active_Ratio, Pclk_Valid high
// PEND   | new ratio requested, waiting for the next PCLK period boundary
// SETTLE | ratio applied, counting SETTLE_PERIODS boundaries before Pclk_Valid
module clk_div_gen #(
    parameter int CNT_W          = 8,
    parameter int SYM_RATIO      = 10,
    parameter int SETTLE_PERIODS = 2
) (
    input  logic             Ref_Clk,
    input  logic             Rst,
    input  logic [5:0]       DataBusWidth,
`ifdef CLK_DIV_GATE_EN
    input  logic             Pclk_Gate_En,
`endif
    output logic             Bit_Rate_CLK_10,
    output logic             PCLK,
    output logic [CNT_W-1:0] Active_Ratio,
    output logic             Pclk_Valid,
    output logic             Ratio_Switch
);
    localparam int ST_W = (SETTLE_PERIODS > 1) ? $clog2(SETTLE_PERIODS) : 1;

    localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);
    localparam logic [CNT_W-1:0] SYM_X1      = CNT_W'(SYM_RATIO);
    localparam logic [CNT_W-1:0] SYM_X2      = CNT_W'(2 * SYM_RATIO);
    localparam logic [CNT_W-1:0] SYM_X4      = CNT_W'(4 * SYM_RATIO);
    localparam logic [CNT_W-1:0] SYM_LAST    = CNT_W'(SYM_RATIO - 1);
    localparam logic [CNT_W-1:0] SYM_HALF    = CNT_W'(SYM_RATIO / 2);
    localparam logic [ST_W-1:0]  SETTLE_LAST = ST_W'(SETTLE_PERIODS - 1);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        PEND   = 2'd1,
        SETTLE = 2'd2
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_sym_cnt, r_pclk_cnt, r_active;
    logic [CNT_W-1:0] w_target, w_active_nxt, w_sym_cnt_nxt, w_pclk_cnt_nxt;
    logic [ST_W-1:0]  r_settle, w_settle_nxt;
    logic             r_sym_clk, r_pclk, r_valid, r_switch, r_first;
    logic             w_valid_nxt, w_switch_nxt, w_pclk_wrap, w_boundary, w_gated_nxt;

    always_comb begin
        case (DataBusWidth)
            6'd8:    w_target = SYM_X1;
            6'd16:   w_target = SYM_X2;
            6'd32:   w_target = SYM_X4;
            default: w_target = SYM_X1;
        endcase
    end

    // The wrap on the first edge after reset starts the first period; it is not a boundary.
    assign w_pclk_wrap    = (r_pclk_cnt == (r_active - ONE));
    assign w_boundary     = w_pclk_wrap & ~r_first;
    assign w_sym_cnt_nxt  = (r_sym_cnt == SYM_LAST) ? '0 : r_sym_cnt + ONE;
    assign w_pclk_cnt_nxt = w_pclk_wrap ? '0 : r_pclk_cnt + ONE;

`ifdef CLK_DIV_GATE_EN
    logic r_gated;
    assign w_gated_nxt = w_pclk_wrap ? ~Pclk_Gate_En : r_gated;

    always_ff @(posedge Ref_Clk) begin
        if (!Rst) r_gated <= 1'b0;
        else      r_gated <= w_gated_nxt;
    end
`else
    assign w_gated_nxt = 1'b0;
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_settle_nxt = r_settle;
        w_active_nxt = r_active;
        w_valid_nxt  = r_valid;
        w_switch_nxt = 1'b0;
        case (r_state)
            RUN: begin
                w_valid_nxt = 1'b1;
                if (w_target != r_active) begin
                    w_state_nxt = PEND;
                    w_valid_nxt = 1'b0;
                end
            end
            PEND: begin
                w_valid_nxt = 1'b0;
                if (w_target == r_active) begin
                    w_state_nxt = RUN;
                    w_valid_nxt = 1'b1;
                end else if (w_boundary) begin
                    w_active_nxt = w_target;
                    w_switch_nxt = 1'b1;
                    w_state_nxt  = SETTLE;
                    w_settle_nxt = '0;
                end
            end
            SETTLE: begin
                w_valid_nxt = 1'b0;
                if (w_target != r_active) begin
                    w_state_nxt = PEND;
                end else if (w_boundary) begin
                    if (r_settle == SETTLE_LAST) begin
                        w_state_nxt  = RUN;
                        w_valid_nxt  = 1'b1;
                        w_settle_nxt = '0;
                    end else begin
                        w_settle_nxt = r_settle + ST_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt  = SETTLE;
                w_settle_nxt = '0;
                w_valid_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Ref_Clk) begin
        if (!Rst) begin
            r_sym_cnt  <= SYM_LAST;
            r_pclk_cnt <= w_target - ONE;
            r_active   <= w_target;
            r_sym_clk  <= 1'b0;
            r_pclk     <= 1'b0;
            r_valid    <= 1'b0;
            r_switch   <= 1'b0;
            r_state    <= SETTLE;
            r_settle   <= '0;
            r_first    <= 1'b1;
        end else begin
            r_sym_cnt  <= w_sym_cnt_nxt;
            r_pclk_cnt <= w_pclk_cnt_nxt;
            r_active   <= w_active_nxt;
            r_sym_clk  <= (w_sym_cnt_nxt < SYM_HALF);
            r_pclk     <= ~w_gated_nxt & (w_pclk_cnt_nxt < (w_active_nxt >> 1));
            r_valid    <= w_valid_nxt;
            r_switch   <= w_switch_nxt;
            r_state    <= w_state_nxt;
            r_settle   <= w_settle_nxt;
            r_first    <= 1'b0;
        end
    end

    assign Bit_Rate_CLK_10 = r_sym_clk;
    assign PCLK            = r_pclk;
    assign Active_Ratio    = r_active;
    assign Pclk_Valid      = r_valid;
    assign Ratio_Switch    = r_switch;

endmodule
